wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master, one-slave Wishbone arbiter for sharing a single peripheral port (e.g. the I2C master slot of the interconnect) between the LM32 data path and a second bus master such as an autonomous sensor poller. Round-robin grant, grant held for a whole `cyc` burst, optional bus-timeout watchdog that terminates hung transfers with `err`. It sits between the interconnect slave port and the shared peripheral.

## Interface
- `ADR_W`, default 32: address width.
- `DAT_W`, default 32: data width; `sel` width is `DAT_W/8`.
- `TIMEOUT_CYCLES`, default 1024: stall limit for the watchdog, legal range 2..65535.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mX_adr_i`  in  ADR_W  address from master X, where X is 0 or 1.
- `mX_dat_i`  in  DAT_W  write data from master X.
- `mX_dat_o`  out  DAT_W  read data to master X; `s_dat_i` broadcast to both masters.
- `mX_sel_i`  in  DAT_W/8  byte selects.
- `mX_we_i`, `mX_cyc_i`, `mX_stb_i`  in  1  Wishbone controls.
- `mX_ack_o`, `mX_err_o`  out  1  termination signals, gated by grant.
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`  out  as master  signals to the shared slave.
- `s_dat_i`  in  DAT_W  read data from the slave.
- `s_ack_i`  in  1  slave ack.
- `grant_o`  out  2  one-hot current grant: bit0 is m0, bit1 is m1, 00 means idle.

## Operation
- FSM states: IDLE, G0, G1. The state is registered. `grant_o` is decoded from the state.
- IDLE:
  - Only m0 `cyc` → G0. Only m1 `cyc` → G1.
  - Both → the master not granted last. The `last` register resets to 1, so m0 wins the first tie.
- G0/G1:
  - Grant is held while the granted master's `cyc_i` is 1. `stb` gaps do not release the grant.
  - When `cyc_i` drops, go to the other state if the other master's `cyc` is 1, otherwise IDLE.
  - `last` is updated on entry to G0/G1.
- Slave outputs are muxed combinationally from the registered grant.
  - In IDLE, `s_cyc_o`, `s_stb_o` and `s_we_o` are 0, and address, data and `sel` are zero.
- `mX_ack_o` = `s_ack_i` & grantX & `mX_stb_i`. The non-granted master never sees ack or err.
- Reset, including mid-transfer: state IDLE, `last` = 1, watchdog counter = 0, all outputs 0. An in-flight slave cycle is abandoned.

## Timing
- Arbitration latency is 1 cycle.
  - Master raises `cyc`/`stb` in cycle N; grant is registered at the edge ending N; `s_cyc_o` is 1 in N+1.
- Back-to-back handover has no dead cycle.
  - Granted `cyc` falls in cycle N; the other master is granted and `s_cyc_o` is driven in N+1.
- Data path and ack path are combinational, with zero added latency once granted.
  - A zero-wait slave gives a single-cycle transfer per `stb`.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter increments each cycle the granted master has `stb` = 1 and `s_ack_i` = 0. It clears on ack, on `stb` = 0 and on grant change.
  - When the count reaches `TIMEOUT_CYCLES`-1:
    - `mX_err_o` pulses 1 for one cycle to the granted master.
    - `s_cyc_o` and `s_stb_o` are forced to 0 that cycle.
    - The counter clears.
  - `s_ack_i` in the same cycle as the timeout takes priority: ack is delivered and err is suppressed.
- Macro undefined:
  - No counter is built.
  - `m0_err_o` and `m1_err_o` are tied to 0.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `wb_arb_pkg`:
  - state encoding constants (IDLE, G0, G1);
  - grant one-hot constants;
  - timeout counter width constant (16).
- One natural sub-module, `wb_arb_timeout`: the stall counter plus err pulse generation. It is instantiated only under `WB_ARB_TIMEOUT_EN`.

## Test plan
- Single master: m0 writes 0xDEADBEEF to 0x60000004; slave acks after 2 waits.
  - `grant_o` = 01 one cycle after `cyc`.
  - `s_adr_o` = 0x60000004.
  - Exactly one `m0_ack_o`; m1 ack stays 0.
- Tie after reset: both assert `cyc` in the same cycle.
  - G0 is granted first.
  - On m0 `cyc` drop, G1 follows the next cycle with no IDLE cycle.
  - In a repeated tie, m1 wins the second arbitration after m0.
- Burst hold: m1 holds `cyc` across 3 `stb` pulses with `stb` gaps while m0 requests.
  - `grant_o` stays 10 for all 3 transfers.
  - m0 is granted only after m1 `cyc` falls.
- Timeout, with macro defined and `TIMEOUT_CYCLES` = 16: slave never acks.
  - `m0_err_o` pulses once, 16 cycles after stb is seen at the slave.
  - `s_cyc_o` = 0 in that cycle.
  - The counter then restarts.
- Reset mid-transfer: `rst` goes low during a G1 wait state.
  - All outputs 0 immediately.
  - After release, a tie grants m0 first.
- Macro undefined, slave never acks:
  - `err` is never asserted.
  - The grant stays 10 indefinitely.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Latency: n/a (types and constants only). Backpressure: n/a.
// State encoding, one-hot grant constants and the stall-counter width.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int TO_CNT_W = 16;

    function automatic logic [1:0] grant_of(input state_t s);
        case (s)
            ST_G0:   grant_of = GNT_M0;
            ST_G1:   grant_of = GNT_M1;
            default: grant_of = GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts stalled strobe cycles of the granted master, flags a timeout.
// Latency: timeout is combinational from the registered count (same cycle).
// Backpressure: none; an ack in the timeout cycle wins and suppresses the timeout.
module wb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    input  logic grant_chg,
    output logic timeout
);
    import wb_arb_pkg::*;

    localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] cnt;

    assign timeout = stb & ~ack & (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (grant_chg || !stb || ack || timeout) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TO_CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter; grant held for a whole cyc burst.
// Latency: 1 cycle to grant, 0 added cycles on data/ack once granted.
// Backpressure: the losing master waits with cyc/stb high; optional watchdog (WB_ARB_TIMEOUT_EN) ends hung transfers with err.
module wb_arbiter2 #(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic               m0_we_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic               m1_we_i,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic               s_we_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    output logic [1:0]         grant_o
);
    import wb_arb_pkg::*;

    state_t state, state_next;
    logic   last;       // 1: m1 was granted most recently, so m0 wins the next tie
    logic   timeout;

    logic [ADR_W-1:0]   mux_adr;
    logic [DAT_W-1:0]   mux_dat;
    logic [DAT_W/8-1:0] mux_sel;
    logic               mux_we;
    logic               mux_cyc;
    logic               mux_stb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next == ST_G0 && state != ST_G0) begin
                last <= 1'b0;
            end else if (state_next == ST_G1 && state != ST_G1) begin
                last <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last ? ST_G0 : ST_G1;
                end else if (m0_cyc_i) begin
                    state_next = ST_G0;
                end else if (m1_cyc_i) begin
                    state_next = ST_G1;
                end
            end
            ST_G0: begin
                if (!m0_cyc_i) begin
                    state_next = m1_cyc_i ? ST_G1 : ST_IDLE;
                end
            end
            ST_G1: begin
                if (!m1_cyc_i) begin
                    state_next = m0_cyc_i ? ST_G0 : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign grant_o = grant_of(state);

    always_comb begin
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        mux_we  = 1'b0;
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        case (state)
            ST_G0: begin
                mux_adr = m0_adr_i;
                mux_dat = m0_dat_i;
                mux_sel = m0_sel_i;
                mux_we  = m0_we_i;
                mux_cyc = m0_cyc_i;
                mux_stb = m0_stb_i;
            end
            ST_G1: begin
                mux_adr = m1_adr_i;
                mux_dat = m1_dat_i;
                mux_sel = m1_sel_i;
                mux_we  = m1_we_i;
                mux_cyc = m1_cyc_i;
                mux_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic grant_chg;
    assign grant_chg = (state_next != state);

    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .stb       (mux_stb),
        .ack       (s_ack_i),
        .grant_chg (grant_chg),
        .timeout   (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    // The timeout cycle drops the slave strobe so the hung access is abandoned.
    assign s_adr_o = mux_adr;
    assign s_dat_o = mux_dat;
    assign s_sel_o = mux_sel;
    assign s_we_o  = mux_we;
    assign s_cyc_o = mux_cyc & ~timeout;
    assign s_stb_o = mux_stb & ~timeout;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = s_ack_i & grant_o[0] & m0_stb_i;
    assign m1_ack_o = s_ack_i & grant_o[1] & m1_stb_i;
    assign m0_err_o = timeout & grant_o[0];
    assign m1_err_o = timeout & grant_o[1];

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomized scoreboard bench for wb_arbiter2 with a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_wb_arbiter2;
    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic [1:0]  we, cyc, stb;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;   // 0 random, 1 never, 2 after two wait states
    xfer_t q0[$];
    xfer_t q1[$];

    wb_arbiter2 #(.ADR_W(32), .DAT_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_dat_o(m0_dat_o), .m0_sel_i(sel[0]),
        .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_dat_o(m1_dat_o), .m1_sel_i(sel[1]),
        .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic done_of(input logic m);
        return m ? (m1_ack_o | m1_err_o) : (m0_ack_o | m0_err_o);
    endfunction

    // Slave: drives ack and read data after the masters have updated.
    int wcnt = 0;
    always @(posedge clk) begin
        #2;
        s_dat_i = $urandom;
        case (ack_mode)
            0: s_ack_i = ($urandom_range(0, 2) == 0);
            2: begin
                if (s_stb_o) begin
                    s_ack_i = (wcnt == 2);
                    wcnt = s_ack_i ? 0 : wcnt + 1;
                end else begin
                    s_ack_i = 1'b0;
                    wcnt = 0;
                end
            end
            default: s_ack_i = 1'b0;
        endcase
    end

    // Reference model: who owns the bus, who won last, and how long the owner has stalled.
    logic own_vld = 1'b0;
    logic own_m   = 1'b0;
    logic last    = 1'b1;
    int   stall   = 0;

    always @(negedge clk) begin : monitor
        logic gcyc, gstb, to, n_vld, n_m;
        logic [1:0] eg;
        xfer_t e;
        if (!rst) begin
            own_vld = 1'b0; own_m = 1'b0; last = 1'b1; stall = 0;
            chk("rst_grant", grant_o, 2'b00);
            chk("rst_bus", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
            chk("rst_adr_dat_sel", {s_adr_o, s_dat_o, s_sel_o}, 68'h0);
            chk("rst_term", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 4'b0000);
        end else begin
            gcyc = own_vld & cyc[own_m];
            gstb = own_vld & stb[own_m];
`ifdef WB_ARB_TIMEOUT_EN
            to = gstb && !s_ack_i && (stall == TO - 1);
`else
            to = 1'b0;
`endif
            eg = !own_vld ? 2'b00 : (own_m ? 2'b10 : 2'b01);
            chk("grant", grant_o, eg);
            chk("s_cyc", s_cyc_o, gcyc & ~to);
            chk("s_stb", s_stb_o, gstb & ~to);
            chk("s_adr", s_adr_o, own_vld ? adr[own_m] : 32'h0);
            chk("s_dat", s_dat_o, own_vld ? dat[own_m] : 32'h0);
            chk("s_sel", s_sel_o, own_vld ? sel[own_m] : 4'h0);
            chk("s_we",  s_we_o,  own_vld & we[own_m]);
            chk("m0_ack", m0_ack_o, s_ack_i & own_vld & !own_m & stb[0]);
            chk("m1_ack", m1_ack_o, s_ack_i & own_vld & own_m & stb[1]);
            chk("m0_err", m0_err_o, to & !own_m);
            chk("m1_err", m1_err_o, to & own_m);
            chk("rdata", {m1_dat_o, m0_dat_o}, {s_dat_i, s_dat_i});

            if (gstb && s_ack_i) begin
                if ((own_m ? q1.size() : q0.size()) == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty ack to master %0d with no expected transfer", own_m);
                end else begin
                    e = own_m ? q1.pop_front() : q0.pop_front();
                    chk("xfer", {s_adr_o, s_dat_o, s_sel_o, s_we_o}, {e.adr, e.dat, e.sel, e.we});
                end
            end else if (to) begin
                if (own_m && q1.size() > 0) void'(q1.pop_front());
                if (!own_m && q0.size() > 0) void'(q0.pop_front());
            end

            if (gstb && !s_ack_i && !to) stall++;
            else stall = 0;

            n_vld = own_vld; n_m = own_m;
            if (!own_vld) begin
                if (cyc == 2'b11) begin n_vld = 1'b1; n_m = !last; end
                else if (cyc[0]) begin n_vld = 1'b1; n_m = 1'b0; end
                else if (cyc[1]) begin n_vld = 1'b1; n_m = 1'b1; end
            end else if (!cyc[own_m]) begin
                if (cyc[!own_m]) n_m = !own_m;
                else n_vld = 1'b0;
            end
            if (n_vld && (!own_vld || n_m != own_m)) last = n_m;
            if (n_vld != own_vld || n_m != own_m) stall = 0;
            own_vld = n_vld; own_m = n_m;
        end
    end

    task automatic burst(input logic m, input int n);
        xfer_t x;
        int w;
        @(posedge clk); #1;
        cyc[m] = 1'b1;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            x.adr = $urandom; x.dat = $urandom; x.sel = 4'($urandom); x.we = 1'($urandom);
            adr[m] = x.adr; dat[m] = x.dat; sel[m] = x.sel; we[m] = x.we;
            stb[m] = 1'b1;
            if (m) q1.push_back(x); else q0.push_back(x);
            w = 0;
            do begin @(negedge clk); w++; end while (!done_of(m) && w < 300);
            if (w >= 300) begin
                checks++; errors++;
                $display("FAIL burst_wait master %0d got no ack within %0d cycles", m, w);
            end
            @(posedge clk); #1;
            stb[m] = 1'b0;
        end
        cyc[m] = 1'b0;
    endtask

    task automatic tie_test(input string name);
        fork
            burst(1'b0, 2);
            burst(1'b1, 2);
        join_none
        @(posedge clk);
        @(negedge clk);
        chk({name, "_req_cycle"}, grant_o, 2'b00);
        @(negedge clk);
        chk({name, "_first"}, grant_o, 2'b01);
        wait fork;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks, errs;
        xfer_t x;
        rst = 1'b0; cyc = 2'b00; stb = 2'b00; we = 2'b00; s_ack_i = 1'b0; s_dat_i = '0;
        for (int i = 0; i < 2; i++) begin adr[i] = '0; dat[i] = '0; sel[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        tie_test("tie_reset");

        // Single write, slave acks after two wait states
        ack_mode = 2;
        @(posedge clk); #1;
        x = '{adr: 32'h6000_0004, dat: 32'hDEAD_BEEF, sel: 4'hF, we: 1'b1};
        adr[0] = x.adr; dat[0] = x.dat; sel[0] = x.sel; we[0] = x.we;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        q0.push_back(x);
        @(negedge clk);
        chk("single_grant_req", grant_o, 2'b00);
        acks = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("single_grant", grant_o, 2'b01);
                chk("single_adr", s_adr_o, 32'h6000_0004);
            end
            if (m0_ack_o) acks++;
            chk("single_m1_ack", m1_ack_o, 1'b0);
            if (k == 3) chk("single_ack_cycle", m0_ack_o, 1'b1);
            @(posedge clk); #1;
            if (k == 3) begin stb[0] = 1'b0; cyc[0] = 1'b0; end
        end
        chk("single_ack_count", acks, 1);

        ack_mode = 0;
        for (int r = 0; r < 25; r++) begin
            fork
                begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    if ($urandom_range(0, 3) != 0) burst(1'b0, $urandom_range(1, 3));
                end
                begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    if ($urandom_range(0, 3) != 0) burst(1'b1, $urandom_range(1, 3));
                end
            join
        end

        // Reset in the middle of a stalled m1 access
        ack_mode = 1;
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        chk("mid_grant", grant_o, 2'b10);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_async", {grant_o, s_cyc_o, s_stb_o}, 4'b0000);
        cyc = 2'b00; stb = 2'b00;
        q1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ack_mode = 0;
        tie_test("tie_after_rst");

        // Slave that never acks: watchdog fires every TO stalled cycles, or never without it
        ack_mode = 1;
        @(posedge clk); #1;
        x = '{adr: 32'hA5A5_0000, dat: 32'h0, sel: 4'h1, we: 1'b0};
        adr[1] = x.adr; dat[1] = x.dat; sel[1] = x.sel; we[1] = x.we;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        q1.push_back(x);
        errs = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (m1_err_o) errs++;
            if (k >= 1) chk("hang_grant", grant_o, 2'b10);
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("hang_err_count", errs, 2);
`else
        chk("hang_err_count", errs, 0);
`endif
        @(posedge clk); #1;
        cyc = 2'b00; stb = 2'b00;
        q1.delete();
        ack_mode = 0;
        repeat (3) @(negedge clk);
        chk("sb_drain0", q0.size(), 0);
        chk("sb_drain1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
